leitor_fila: RTL and testbench
==============================

// Module: leitor_fila
// PURPOSE
//  Read-side controller of the one-to-N-entry buffer whose occupancy is tracked by the inc/dec occupancy counter.
//  Watches the counter's empty flag and fetches the word at the read pointer from storage.
//  Issues the dec pulse and presents the word on a registered valid/ready output port.
//  Sits between buffer storage + occupancy counter (upstream) and the consumer (downstream).
// PARAMETERS
//  WIDTH   8   data word width in bits
//  DEPTH   2   buffer entries; any value >= 1, power of two not required
//  PTR_W   1   read-pointer width; must satisfy 2**PTR_W >= DEPTH
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  rst_n      in   1        asynchronous reset, active low
//  empty      in   1        occupancy counter empty flag (1 = nothing stored)
//  rd_data    in   WIDTH    storage word at rd_ptr; combinational read, valid same cycle
//  out_ready  in   1        consumer accepts out_data this cycle
//  dec        out  1        pop pulse to occupancy counter dec input; combinational, one cycle per word
//  rd_ptr     out  PTR_W    storage read address
//  out_data   out  WIDTH    registered output word
//  out_valid  out  1        out_data holds an undelivered word
// BEHAVIOUR
//  Reset (rst_n=0, async, any cycle incl. mid-transfer)
//   - rd_ptr=0, out_data=0, out_valid=0, FSM=VAZIO.
//   - dec=0 while rst_n=0.
//  FSM states
//   - VAZIO: out_valid=0.
//   - CHEIO: out_valid=1.
//   - out_valid is the decoded state bit, no separate register.
//  pop = ~empty & (~out_valid | out_ready); dec = pop.
//  On pop at rising edge
//   - out_data <= rd_data.
//   - rd_ptr <= (rd_ptr==DEPTH-1) ? 0 : rd_ptr+1.
//   - FSM -> CHEIO.
//  Transitions
//   - VAZIO & empty -> stay VAZIO.
//   - VAZIO & ~empty -> pop -> CHEIO.
//   - CHEIO & ~out_ready -> hold; out_data and rd_ptr frozen; dec=0.
//   - CHEIO & out_ready & ~empty -> pop; stay CHEIO (back-to-back, 1 word/cycle).
//   - CHEIO & out_ready & empty -> VAZIO; out_data keeps last value.
//  Latency: word stored while VAZIO appears on out_data/out_valid one cycle after empty falls.
//  Boundaries
//   - Never pops while empty=1; no underflow possible.
//   - rd_ptr wraps DEPTH-1 -> 0.
//   - DEPTH=1: rd_ptr constant 0.
//   - Write and pop in the same cycle are resolved by the occupancy counter; this block does not observe inc.
//   - rd_data is sampled only on pop; changes at other times are ignored.
//   - out_ready while VAZIO has no effect.
// STRUCTURE
//  Shared include file leitor_defs.vh
//   - state encoding: VAZIO=1'b0, CHEIO=1'b1.
//   - default WIDTH/DEPTH values.
//  Sub-module contador_ponteiro
//   - PTR_W-bit wrap-at-DEPTH-1 incrementer with enable and active-low async clear.
//   - instantiated once for rd_ptr.
//  Data register: WIDTH D flip-flops with active-low async clear, enable = pop.
//  FSM: one flip-flop plus gate-level next-state/pop logic, built structurally from primitives.
// TESTING
//  1. Reset release, empty=1 for 5 cycles
//     -> out_valid=0, dec=0, rd_ptr=0, out_data=0 throughout.
//  2. empty=0, rd_data=8'hA5, out_ready=0
//     -> dec=1 for exactly one cycle; next cycle out_valid=1, out_data=A5, rd_ptr=1.
//     -> then holds with dec=0.
//  3. DEPTH=2, empty stays 0, out_ready=1, rd_data 11,22,33
//     -> dec=1 every cycle; out_data 11,22,33 on consecutive cycles; rd_ptr 1,0,1.
//  4. CHEIO, out_ready=1, empty=1
//     -> next cycle out_valid=0, out_data keeps last word, dec=0.
//  5. rst_n low mid-stream while out_valid=1, rd_ptr=1
//     -> immediately out_valid=0, rd_ptr=0, out_data=0, dec=0, without a clock edge.
//  6. DEPTH=3, PTR_W=2, 4 pops
//     -> rd_ptr sequence 1,2,0,1; never reaches 3.

Source files
------------

// File: rtl/leitor_fila_pkg.sv
// Shared definitions for the buffer read-side controller: state encoding and default sizes.
package leitor_fila_pkg;

    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_PTR_W = 1;

endpackage

// File: rtl/leitor_fila_contador_ponteiro.sv
// Read-pointer incrementer: advances on enable and wraps from DEPTH-1 back to 0.
module contador_ponteiro #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [PTR_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    // With DEPTH=1, LAST is 0, so the pointer never leaves 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/leitor_fila.sv
// Read-side controller: pops words from buffer storage and holds them on a registered valid/ready port.
module leitor_fila
    import leitor_fila_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = DEF_PTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             empty,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             out_ready,
    output logic             dec,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    estado_t state;
    estado_t state_next;
    logic    pop;

    assign out_valid = (state == CHEIO);

    // Gated by rst_n so the counter never sees a pop while reset is asserted.
    assign pop = rst_n & ~empty & (~out_valid | out_ready);
    assign dec = pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= VAZIO;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (pop) begin
            state_next = CHEIO;
        end else if ((state == CHEIO) && out_ready) begin
            state_next = VAZIO;
        end
    end

    // out_data keeps its last word when the consumer drains the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (pop) begin
            out_data <= rd_data;
        end
    end

    contador_ponteiro #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) u_ptr (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (pop),
        .count(rd_ptr)
    );

endmodule

// File: tb/tb_leitor_fila.sv
// Directed bench for leitor_fila with a DEPTH=2 and a DEPTH=3 instance.
module tb_leitor_fila;

    logic       clk;
    logic       rst_n;

    logic       empty;
    logic [7:0] rd_data;
    logic       out_ready;
    logic       dec;
    logic [0:0] rd_ptr;
    logic [7:0] out_data;
    logic       out_valid;

    logic       empty3;
    logic [7:0] rd_data3;
    logic       out_ready3;
    logic       dec3;
    logic [1:0] rd_ptr3;
    logic [7:0] out_data3;
    logic       out_valid3;

    int n_compared;
    int n_mismatched;

    leitor_fila #(.WIDTH(8), .DEPTH(2), .PTR_W(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .empty    (empty),
        .rd_data  (rd_data),
        .out_ready(out_ready),
        .dec      (dec),
        .rd_ptr   (rd_ptr),
        .out_data (out_data),
        .out_valid(out_valid)
    );

    leitor_fila #(.WIDTH(8), .DEPTH(3), .PTR_W(2)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .empty    (empty3),
        .rd_data  (rd_data3),
        .out_ready(out_ready3),
        .dec      (dec3),
        .rd_ptr   (rd_ptr3),
        .out_data (out_data3),
        .out_valid(out_valid3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic [7:0] d, input logic r);
        empty     = e;
        rd_data   = d;
        out_ready = r;
    endtask

    task automatic checkPort(input string tag, input logic v, input logic [7:0] d,
                             input logic p, input logic dc);
        checkOutput({tag, ".valid"}, 32'(out_valid), 32'(v));
        checkOutput({tag, ".data"},  32'(out_data),  32'(d));
        checkOutput({tag, ".ptr"},   32'(rd_ptr),    32'(p));
        checkOutput({tag, ".dec"},   32'(dec),       32'(dc));
    endtask

    logic [7:0] stream [3];
    logic       exp_ptr;

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        stream[0] = 8'h11;
        stream[1] = 8'h22;
        stream[2] = 8'h33;

        // Reset with empty=0: dec must stay low while rst_n is asserted.
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h5A, 1'b0);
        empty3 = 1'b1; rd_data3 = 8'h00; out_ready3 = 1'b0;
        #12;
        checkPort("reset", 1'b0, 8'h00, 1'b0, 1'b0);

        applyStimulus(1'b1, 8'h5A, 1'b0);
        tick();
        rst_n = 1'b1;

        // Idle while empty; out_ready toggled to show it has no effect in VAZIO.
        for (int i = 0; i < 5; i++) begin
            out_ready = i[0];
            tick();
            checkPort($sformatf("idle%0d", i), 1'b0, 8'h00, 1'b0, 1'b0);
        end

        // Single word with a stalled consumer.
        applyStimulus(1'b0, 8'hA5, 1'b0);
        #1;
        checkOutput("first.dec", 32'(dec), 32'd1);
        tick();
        checkPort("first", 1'b1, 8'hA5, 1'b1, 1'b0);
        rd_data = 8'h77;
        tick();
        checkPort("hold", 1'b1, 8'hA5, 1'b1, 1'b0);

        // Back-to-back streaming, pointer continues from 1.
        out_ready = 1'b1;
        exp_ptr   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_data = stream[i];
            #1;
            checkOutput($sformatf("stream%0d.dec", i), 32'(dec), 32'd1);
            tick();
            exp_ptr = ~exp_ptr;
            checkPort($sformatf("stream%0d", i), 1'b1, stream[i], exp_ptr, 1'b1);
        end

        // Drain: consumer takes last word, buffer empty.
        applyStimulus(1'b1, 8'h99, 1'b1);
        #1;
        checkOutput("drain.dec", 32'(dec), 32'd0);
        tick();
        checkPort("drain", 1'b0, 8'h33, 1'b0, 1'b0);

        // Load one word, then assert reset mid-cycle without a clock edge.
        applyStimulus(1'b0, 8'h44, 1'b0);
        tick();
        checkPort("preload", 1'b1, 8'h44, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkPort("async_rst", 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b0);
        tick();
        rst_n = 1'b1;

        // DEPTH=3: pointer sequence 1,2,0,1.
        empty3     = 1'b0;
        out_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_data3 = 8'hC0 + 8'(i);
            tick();
            checkOutput($sformatf("d3_ptr%0d", i), 32'(rd_ptr3), 32'((i + 1) % 3));
            checkOutput($sformatf("d3_data%0d", i), 32'(out_data3), 32'(8'hC0 + 8'(i)));
            checkOutput($sformatf("d3_valid%0d", i), 32'(out_valid3), 32'd1);
        end
        empty3 = 1'b1;
        tick();
        checkOutput("d3_drain", 32'(out_valid3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
